lfsr_histogram: RTL

- Downstream consumer of the LFSR core's AXI-Stream output (lfsr_m_axis_tdata/tvalid).
- Accumulates a histogram of incoming 32-bit samples into 2^NUM_BINS_LOG2 bins, binned on the upper bits of the low byte.
- After each frame of SAMPLE_COUNT samples, or on software request, it streams the bin counts out on an AXI-Stream master port (hist_m_axis_*).
- It then clears the counts and starts collecting the next frame.

---
 rtl/lfsr_histogram.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_histogram.sv
// Histogram collector for the LFSR AXI-Stream: bins samples per frame and dumps bin records on hist_m_axis.
// Optional build macro HIST_OVERFLOW_FLAG_EN adds a sticky per-bin saturation flag reported in record bit 23.

module lfsr_histogram #(
    parameter int NUM_BINS_LOG2 = 4,
    parameter int COUNT_W       = 16,
    parameter int SAMPLE_COUNT  = 256
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        dump_req,
    output logic [31:0] hist_m_axis_tdata,
    output logic        hist_m_axis_tvalid,
    input  logic        hist_m_axis_tready,
    output logic        hist_m_axis_tlast,
    output logic        frame_done,
    output logic        busy
);

    localparam int NUM_BINS = 1 << NUM_BINS_LOG2;
    localparam int SCNT_W   = $clog2(SAMPLE_COUNT + 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DUMP    = 2'd1;
    localparam logic [1:0] ST_CLEAR   = 2'd2;

    localparam logic [COUNT_W-1:0]       COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0]       COUNT_ONE = COUNT_W'(1);
    localparam logic [NUM_BINS_LOG2-1:0] IDX_LAST  = {NUM_BINS_LOG2{1'b1}};
    localparam logic [NUM_BINS_LOG2-1:0] IDX_ONE   = NUM_BINS_LOG2'(1);
    localparam logic [SCNT_W-1:0]        SCNT_ONE  = SCNT_W'(1);
    localparam logic [SCNT_W-1:0]        SCNT_FULL = SCNT_W'(SAMPLE_COUNT);

    logic [1:0]               state_r;
    logic [1:0]               next_state_s;
    logic [COUNT_W-1:0]       bins_r [NUM_BINS];
    logic [SCNT_W-1:0]        sample_cnt_r;
    logic [SCNT_W-1:0]        sample_cnt_inc_s;
    logic [NUM_BINS_LOG2-1:0] dump_idx_r;
    logic [NUM_BINS_LOG2-1:0] in_bin_s;
    logic [NUM_BINS_LOG2-1:0] rec_idx_s;
    logic                     in_hs_s;
    logic                     out_hs_s;
    logic                     bin_at_max_s;
    logic                     rec_flag_s;
    logic [31:0]              rec_data_s;
    logic                     unused_tdata_s;

    // Record layout: bin index in [31:24], saturation flag in [23], count in [22:0].
    function automatic logic [31:0] make_record(
        input logic [NUM_BINS_LOG2-1:0] idx,
        input logic                     flag,
        input logic [COUNT_W-1:0]       cnt
    );
        make_record = {8'(idx), flag, 23'(cnt)};
    endfunction

    // Only the binning bits of the sample are meaningful; the rest is deliberately ignored.
    assign unused_tdata_s = ^s_axis_tdata;

    // Handshake detection and sample binning.
    always_comb begin
        in_hs_s          = (state_r == ST_COLLECT) & s_axis_tvalid & s_axis_tready;
        out_hs_s         = (state_r == ST_DUMP) & hist_m_axis_tvalid & hist_m_axis_tready;
        in_bin_s         = s_axis_tdata[7 -: NUM_BINS_LOG2];
        sample_cnt_inc_s = sample_cnt_r + SCNT_ONE;
        bin_at_max_s     = (bins_r[in_bin_s] == COUNT_MAX);
    end

    // Next-state logic; frame-full and dump_req collapse into one COLLECT->DUMP transition.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_COLLECT: begin
                if ((in_hs_s && (sample_cnt_inc_s == SCNT_FULL)) || dump_req) begin
                    next_state_s = ST_DUMP;
                end else begin
                    next_state_s = ST_COLLECT;
                end
            end
            ST_DUMP: begin
                if (out_hs_s && hist_m_axis_tlast) begin
                    next_state_s = ST_CLEAR;
                end else begin
                    next_state_s = ST_DUMP;
                end
            end
            ST_CLEAR: next_state_s = ST_COLLECT;
            default:  next_state_s = ST_COLLECT;
        endcase
    end

    // Record to present next: the current index before the first record, else the following one.
    always_comb begin
        if (hist_m_axis_tvalid) begin
            rec_idx_s = dump_idx_r + IDX_ONE;
        end else begin
            rec_idx_s = dump_idx_r;
        end
        rec_data_s = make_record(rec_idx_s, rec_flag_s, bins_r[rec_idx_s]);
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r       <= ST_COLLECT;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            s_axis_tready <= (next_state_s == ST_COLLECT);
            busy          <= (next_state_s != ST_COLLECT);
            frame_done    <= (state_r == ST_DUMP) && (next_state_s == ST_CLEAR);
        end
    end

    // Bin counters and sample counter; counters saturate instead of wrapping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_r[i] <= {COUNT_W{1'b0}};
            end
            sample_cnt_r <= {SCNT_W{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                bins_r[i] <= {COUNT_W{1'b0}};
            end
            sample_cnt_r <= {SCNT_W{1'b0}};
        end else if (in_hs_s) begin
            sample_cnt_r <= sample_cnt_inc_s;
            if (!bin_at_max_s) begin
                bins_r[in_bin_s] <= bins_r[in_bin_s] + COUNT_ONE;
            end
        end
    end

`ifdef HIST_OVERFLOW_FLAG_EN
    logic [NUM_BINS-1:0] ovf_r;

    // Sticky saturation flags, set when an increment hits a full counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ovf_r <= {NUM_BINS{1'b0}};
        end else if (state_r == ST_CLEAR) begin
            ovf_r <= {NUM_BINS{1'b0}};
        end else if (in_hs_s && bin_at_max_s) begin
            ovf_r[in_bin_s] <= 1'b1;
        end
    end

    // Flag of the record about to be presented.
    always_comb begin
        rec_flag_s = ovf_r[rec_idx_s];
    end
`else
    // No flag storage in this build; record bit 23 stays zero.
    always_comb begin
        rec_flag_s = 1'b0;
    end
`endif

    // Dump output channel: records are held stable until accepted, one per cycle when tready stays high.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hist_m_axis_tvalid <= 1'b0;
            hist_m_axis_tlast  <= 1'b0;
            hist_m_axis_tdata  <= 32'd0;
            dump_idx_r         <= {NUM_BINS_LOG2{1'b0}};
        end else begin
            case (state_r)
                ST_DUMP: begin
                    if (!hist_m_axis_tvalid) begin
                        hist_m_axis_tvalid <= 1'b1;
                        hist_m_axis_tdata  <= rec_data_s;
                        hist_m_axis_tlast  <= (rec_idx_s == IDX_LAST);
                    end else if (hist_m_axis_tready) begin
                        if (hist_m_axis_tlast) begin
                            hist_m_axis_tvalid <= 1'b0;
                            hist_m_axis_tlast  <= 1'b0;
                            hist_m_axis_tdata  <= 32'd0;
                        end else begin
                            dump_idx_r        <= rec_idx_s;
                            hist_m_axis_tdata <= rec_data_s;
                            hist_m_axis_tlast <= (rec_idx_s == IDX_LAST);
                        end
                    end
                end
                ST_CLEAR: begin
                    dump_idx_r <= {NUM_BINS_LOG2{1'b0}};
                end
                default: begin
                    hist_m_axis_tvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
